data_mem_arbiter: RTL
=====================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning):
- ADDR_W, 6, memory word-address width.
- DATA_W, 32, data word width.

REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- Clock, in, 1: single clock; all state updates on posedge.
- Reset, in, 1: asynchronous, active-high reset.
- Req0/Req1, in, 1: requester 0/1 access request; held high with payload stable until the matching Gnt is seen.
- We0/We1, in, 1: 1 = write, 0 = read.
- Addr0/Addr1, in, ADDR_W: word address.
- WData0/WData1, in, DATA_W: write data.
- Gnt0/Gnt1, out, 1: one-cycle pulse; payload was sampled on the preceding edge.
- RValid0/RValid1, out, 1: one-cycle pulse; RData for that port is valid.
- RData0/RData1, out, DATA_W: read data, held until the next read completes for that port.
- MemRead, out, 1: memory read strobe.
- MemWrite, out, 1: memory write strobe.
- MemAddr, out, ADDR_W: memory address.
- MemWData, out, DATA_W: memory write data.
- MemRData, in, DATA_W: memory read data; registered by the memory on the posedge that ends a MemRead cycle.
- Busy, out, 1: high whenever state is not IDLE.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ISSUE, RESP.

REQ-004 In IDLE with no Req, the block SHALL stay in IDLE with MemRead = MemWrite = 0.

REQ-005 In IDLE with at least one Req high on edge E0, the block SHALL:
- select a winner;
- register the winner's We, Addr and WData into MemAddr, MemWData and an internal op register;
- pulse Gnt of the winner for the cycle E0–E1;
- go to ISSUE.

REQ-006 Arbitration SHALL be round-robin:
- a single requester always wins;
- when both request, the port not granted last wins;
- the last-grant pointer updates only on grant.

REQ-007 In ISSUE (cycle E0–E1), exactly one of MemRead or MemWrite SHALL be 1, per the latched op; MemAddr and MemWData SHALL be stable for the whole cycle (write completes on the negedge inside it).

REQ-008 From ISSUE:
- a write SHALL go to IDLE at E1;
- a read SHALL go to RESP at E1.

REQ-009 In RESP (cycle E1–E2), MemRead and MemWrite SHALL be 0. At E2 the block SHALL:
- capture MemRData into RData of the latched port;
- pulse that port's RValid for cycle E2–E3;
- go to IDLE.

REQ-010 Latency and throughput SHALL be:
- read: Gnt in cycle 1, RValid in cycle 3 after the accepting edge;
- write: Gnt in cycle 1, memory written in cycle 1;
- back-to-back throughput: one write per 2 cycles, one read per 3 cycles.

REQ-011 Req SHALL be sampled only in IDLE; requests arriving in ISSUE or RESP wait without loss.

REQ-012 Because the requester drops Req after seeing Gnt, a granted request SHALL never be accepted twice; the block relies on this without extra tracking.

REQ-013 MemRead and MemWrite SHALL never be high simultaneously and SHALL each be high for at most one consecutive cycle per grant.

REQ-014 RValid0 and RValid1 SHALL never be high simultaneously; Gnt0 and Gnt1 likewise.

REQ-015 RData of the non-completing port SHALL hold its value.

REQ-016 A read and a write to the same address in consecutive grants SHALL observe program order: a write granted before a read returns the new data.

Reset
REQ-017 On Reset high, asynchronously:
- state SHALL become IDLE;
- the last-grant pointer SHALL become 1, so port 0 wins the first contention;
- all outputs SHALL become 0: Gnt, RValid, RData, MemRead, MemWrite, MemAddr, MemWData, Busy.

REQ-018 Reset asserted in ISSUE or RESP SHALL abort the access:
- no RValid issued afterward;
- no MemRead/MemWrite after reset assertion.

REQ-019 After Reset deasserts, the first IDLE edge SHALL sample Req normally.

Verification
REQ-020 Scenario: single write then read.
- Stimulus: Req0 write Addr0 = 5, WData0 = 0xDEADBEEF; then Req0 read Addr0 = 5.
- Required: Gnt0 pulses; MemWrite = 1 for 1 cycle with MemAddr = 5; read RValid0 arrives 3 cycles after the accept edge with RData0 = 0xDEADBEEF.

REQ-021 Scenario: contention from reset.
- Stimulus: Req0 and Req1 both high continuously, both reads, Addr0 = 1, Addr1 = 2.
- Required: grants alternate 0, 1, 0, 1; MemAddr alternates 1, 2; each RValid goes to the matching port.

REQ-022 Scenario: port 1 alone.
- Stimulus: Req1 write Addr1 = 63, WData1 = 0x12345678, with Req0 = 0.
- Required: Gnt1 pulses; MemAddr = 63; Gnt0 never asserts.

REQ-023 Scenario: request during busy.
- Stimulus: Req1 raised during the RESP cycle of a port-0 read.
- Required: Req1 is accepted at the first IDLE edge; no MemRead overlap occurs.

REQ-024 Scenario: reset mid-read.
- Stimulus: Reset pulsed during RESP of a port-0 read.
- Required: RValid0 stays 0; all outputs are 0; the next Req0 read completes normally with correct data.

REQ-025 Scenario: protocol checks.
- Stimulus: all of the above scenarios.
- Required: assertions hold throughout that MemRead and MemWrite are never both 1, Gnt0 and Gnt1 are never both 1, and Busy equals (state != IDLE).

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported synchronous data memory.
// One access in flight at a time: IDLE -> ISSUE (-> RESP for reads) -> IDLE.
module data_mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              RValid0,
  output logic              RValid1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state, next_state;
  logic   op_we;
  logic   op_port;
  logic   last;
  logic   win;
  logic   accept;

  // Contention goes to the port not granted last; a lone requester always wins.
  assign win    = (Req0 && Req1) ? ~last : Req1;
  assign accept = (state == IDLE) && (Req0 || Req1);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    Gnt0       = 1'b0;
    Gnt1       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    case (state)
      IDLE:  if (Req0 || Req1) next_state = ISSUE;
      ISSUE: begin
        Gnt0       = ~op_port;
        Gnt1       = op_port;
        MemRead    = ~op_we;
        MemWrite   = op_we;
        next_state = op_we ? IDLE : RESP;
      end
      RESP:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

  // Winner payload latched on the accepting edge; held stable through ISSUE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_we    <= 1'b0;
      op_port  <= 1'b0;
      last     <= 1'b1;
      MemAddr  <= '0;
      MemWData <= '0;
    end else if (accept) begin
      op_port  <= win;
      last     <= win;
      op_we    <= win ? We1 : We0;
      MemAddr  <= win ? Addr1 : Addr0;
      MemWData <= win ? WData1 : WData0;
    end
  end

  // Memory data is registered at the end of ISSUE, so it is valid throughout RESP.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      RValid0 <= 1'b0;
      RValid1 <= 1'b0;
      RData0  <= '0;
      RData1  <= '0;
    end else begin
      RValid0 <= (state == RESP) && !op_port;
      RValid1 <= (state == RESP) && op_port;
      if (state == RESP && !op_port) RData0 <= MemRData;
      if (state == RESP && op_port)  RData1 <= MemRData;
    end
  end

endmodule
